// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Shares one 1-bit full-adder cell between two requesters and performs
//   WIDTH-bit additions bit-serially, LSB first. Round-robin arbitration
//   picks a winner in IDLE; the winner's operands are then shifted through
//   the adder cell over WIDTH cycles.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req0/a0/b0/cin0      requester 0 request, operands, carry-in
//   req1/a1/b1/cin1      requester 1 request, operands, carry-in
//   gnt0, gnt1           one-cycle pulse: operands of that requester captured
//   busy                 high while an addition is in progress
//   done, done_id        one-cycle result-valid pulse and owning requester
//   sum, cout            result and final carry, held until the next done
//   ovf                  signed overflow of the completed add
//                        (present only when SERIAL_ADD_OVF_EN is defined)
//
// Optional feature macro: SERIAL_ADD_OVF_EN

// Single-bit full-adder cell shared by both requesters.
module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    typedef enum logic {IDLE, RUN} state_t;

    // Counter needs at least one bit even for WIDTH == 1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               last_q, last_d;
    logic               id_q, id_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               done_q, done_d;
    logic               done_id_q, done_id_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic fa_s, fa_co;
    logic any_req;
    logic winner;
    logic last_bit;

    serial_add_fa u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign any_req  = req0 | req1;
    // On a tie the requester that did not win last time gets the adder.
    assign winner   = (req0 && req1) ? ~last_q : req1;
    assign last_bit = (cnt_q == LAST_CNT);

    // State register and all datapath flops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            id_q      <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            id_q      <= id_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_req)  state_d = RUN;
            RUN:     if (last_bit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output logic.
    always_comb begin
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        id_d      = id_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    a_sh_d  = winner ? a1 : a0;
                    b_sh_d  = winner ? b1 : b0;
                    carry_d = winner ? cin1 : cin0;
                    cnt_d   = '0;
                    last_d  = winner;
                    id_d    = winner;
                    gnt0_d  = ~winner;
                    gnt1_d  = winner;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                // Each new sum bit enters at the MSB, so after WIDTH shifts
                // the first (LSB) bit has arrived at position 0.
                res_d   = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    sum_d     = res_d;
                    cout_d    = fa_co;
                    done_id_d = id_q;
                    done_d    = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB on the final step.
                    ovf_d     = carry_q ^ fa_co;
`endif
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state_q == RUN);
    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against an arithmetic model.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1, cin0, cin1;
    logic [W-1:0] a0, b0, a1, b1;
    logic         gnt0, gnt1, busy, done, done_id, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
`ifdef SERIAL_ADD_OVF_EN
        .ovf     (ovf),
`endif
        .cout    (cout)
    );

    always #5 clk = ~clk;

    // Reference model: one add is an arithmetic a+b+cin whose result appears
    // W cycles after the grant edge; arbitration is plain round robin.
    bit           m_valid = 1'b0;
    bit           m_busy, m_last, m_gnt0, m_gnt1, m_done, m_id, m_cout, m_ovf;
    int           m_left;
    logic [W-1:0] m_sum;
    logic [W:0]   p_full;
    bit           p_id, p_ovf;

    always @(posedge clk) begin
        logic [W-1:0] pa, pb;
        bit           w, pc;
        if (!rst_n) begin
            m_busy = 0; m_left = 0; m_last = 1; m_gnt0 = 0; m_gnt1 = 0;
            m_done = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
            m_valid = 1;
        end else if (m_valid) begin
            m_gnt0 = 0; m_gnt1 = 0; m_done = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0; m_done = 1;
                    m_sum  = p_full[W-1:0];
                    m_cout = p_full[W];
                    m_id   = p_id;
                    m_ovf  = p_ovf;
                end
            end else if (req0 || req1) begin
                w      = (req0 && req1) ? !m_last : req1;
                pa     = w ? a1 : a0;
                pb     = w ? b1 : b0;
                pc     = w ? cin1 : cin0;
                p_full = {1'b0, pa} + {1'b0, pb} + (W+1)'(pc);
                p_ovf  = (pa[W-1] == pb[W-1]) && (p_full[W-1] != pa[W-1]);
                p_id   = w;
                m_last = w;
                m_busy = 1;
                m_left = W;
                m_gnt0 = !w;
                m_gnt1 = w;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            checkOutput("busy",    32'(busy),    32'(m_busy));
            checkOutput("gnt0",    32'(gnt0),    32'(m_gnt0));
            checkOutput("gnt1",    32'(gnt1),    32'(m_gnt1));
            checkOutput("done",    32'(done),    32'(m_done));
            checkOutput("done_id", 32'(done_id), 32'(m_id));
            checkOutput("sum",     32'(sum),     32'(m_sum));
            checkOutput("cout",    32'(cout),    32'(m_cout));
`ifdef SERIAL_ADD_OVF_EN
            checkOutput("ovf",     32'(ovf),     32'(m_ovf));
`endif
        end
    end

    task automatic applyStimulus(input bit who, input logic [W-1:0] a,
                                 input logic [W-1:0] b, input bit c);
        if (who) begin
            req1 = 1'b1; a1 = a; b1 = b; cin1 = c;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b; cin0 = c;
        end
    endtask

    // Waits (bounded) for either grant; returns cycles waited or -1.
    task automatic waitGnt(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                n = i;
                break;
            end
        end
        if (n < 0) checkOutput("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitDone(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n < 0) checkOutput("done_timeout", 32'd0, 32'd1);
    endtask

    // Complete add for one requester; lat = cycles from grant to done.
    task automatic runAdd(input bit who, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit c, output int lat);
        int n;
        @(negedge clk);
        applyStimulus(who, a, b, c);
        waitGnt(n);
        if (who) req1 = 1'b0; else req0 = 1'b0;
        waitDone(lat);
    endtask

    initial begin
        int lat, n, cnt;
        rst_n = 1'b0; req0 = 0; req1 = 0; cin0 = 0; cin1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_sum",  32'(sum),  32'd0);

        // Tie right after reset: requester 0 first, then 1, then 0 again.
        applyStimulus(1'b0, 8'h10, 8'h01, 1'b0);
        applyStimulus(1'b1, 8'h20, 8'h02, 1'b0);
        waitGnt(n);
        checkOutput("tie1_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        waitDone(lat);
        checkOutput("tie1_sum", 32'(sum), 32'h11);
        checkOutput("tie1_id",  32'(done_id), 32'd0);
        waitGnt(n);
        checkOutput("tie2_gnt_delay", 32'(n), 32'd1);
        checkOutput("tie2_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        waitDone(lat);
        checkOutput("tie2_sum", 32'(sum), 32'h22);
        checkOutput("tie2_id",  32'(done_id), 32'd1);
        applyStimulus(1'b0, 8'h03, 8'h04, 1'b0);
        applyStimulus(1'b1, 8'h05, 8'h06, 1'b0);
        waitGnt(n);
        checkOutput("tie3_gnt0", 32'(gnt0), 32'd1);
        req0 = 1'b0;
        waitDone(lat);
        checkOutput("tie3_sum", 32'(sum), 32'h07);
        waitGnt(n);
        req1 = 1'b0;
        waitDone(lat);
        checkOutput("tie4_sum", 32'(sum), 32'h0B);

        // Single add and wrap-around.
        runAdd(1'b0, 8'h5A, 8'h3C, 1'b0, lat);
        checkOutput("add1_latency", 32'(lat), 32'(W));
        checkOutput("add1_sum",  32'(sum), 32'h96);
        checkOutput("add1_cout", 32'(cout), 32'd0);
        checkOutput("add1_id",   32'(done_id), 32'd0);
        runAdd(1'b1, 8'hFF, 8'h01, 1'b0, lat);
        checkOutput("wrap_sum",  32'(sum), 32'h00);
        checkOutput("wrap_cout", 32'(cout), 32'd1);
        checkOutput("wrap_id",   32'(done_id), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("wrap_ovf",  32'(ovf), 32'd0);
`endif

        // Overlap: requester 1 arrives mid-run and waits for IDLE.
        @(negedge clk);
        applyStimulus(1'b0, 8'h11, 8'h22, 1'b1);
        waitGnt(n);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 8'h40, 8'h40, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (gnt1) cnt++;
        end
        checkOutput("ovl_no_early_gnt1", 32'(cnt), 32'd0);
        checkOutput("ovl_sum0", 32'(sum), 32'h34);
        waitGnt(n);
        checkOutput("ovl_gnt_delay", 32'(n), 32'd1);
        checkOutput("ovl_gnt1", 32'(gnt1), 32'd1);
        req1 = 1'b0;
        waitDone(lat);
        checkOutput("ovl_sum1", 32'(sum), 32'h80);

        // Reset in the middle of a run.
        @(negedge clk);
        applyStimulus(1'b0, 8'hAA, 8'h55, 1'b0);
        waitGnt(n);
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sum",  32'(sum),  32'd0);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        checkOutput("rst_no_done", 32'(cnt), 32'd0);
        runAdd(1'b0, 8'h01, 8'h01, 1'b1, lat);
        checkOutput("post_rst_sum", 32'(sum), 32'h03);

        // Signed overflow case.
        runAdd(1'b1, 8'h7F, 8'h01, 1'b0, lat);
        checkOutput("ovf_sum",  32'(sum), 32'h80);
        checkOutput("ovf_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("ovf_flag", 32'(ovf), 32'd1);
`endif

        // Randomized traffic; the every-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
            end else begin
                if (req0 && gnt0) req0 = 1'b0;
                else if (!req0 && $urandom_range(0, 3) == 0)
                    applyStimulus(1'b0, W'($urandom), W'($urandom), 1'($urandom));
                if (req1 && gnt1) req1 = 1'b0;
                else if (!req1 && $urandom_range(0, 3) == 0)
                    applyStimulus(1'b1, W'($urandom), W'($urandom), 1'($urandom));
            end
        end
        rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Time-shares one 1-bit full-adder cell between two requesters and performs WIDTH-bit additions bit-serially, LSB first.
- Holds operand and result shift registers, the carry flip-flop, a bit counter, and round-robin arbitration.
- Sits between client logic and the shared full-adder datapath.
- The full-adder cell is instantiated inside this block.

Parameters:
- WIDTH, 8, operand/result width in bits (WIDTH >= 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 add request.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- cin0  input  1  requester 0 carry-in.
- req1  input  1  requester 1 add request.
- a1  input  WIDTH  requester 1 operand A.
- b1  input  WIDTH  requester 1 operand B.
- cin1  input  1  requester 1 carry-in.
- gnt0  output  1  one-cycle pulse: requester 0 operands captured.
- gnt1  output  1  one-cycle pulse: requester 1 operands captured.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: result valid.
- done_id  output  1  requester owning the current result (0/1).
- sum  output  WIDTH  result, held until the next done.
- cout  output  1  final carry-out, held until the next done.

Behaviour:
- Reset: clk/rst_n as named above; reset is synchronous, active-low.
  - While rst_n is low at a clk edge, all outputs, shift registers, counter and carry go to 0.
  - The round-robin pointer (last) is set to 1, so requester 0 wins the first tie.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE, edge where any req is high:
  - Winner is the single requester asserting req. If both assert, the winner is the one not equal to last.
  - Capture winner's a/b into shift regs and its cin into the carry FF; cnt=0; last<=winner; id<=winner.
  - Go to RUN.
  - gnt_winner is high for exactly the next cycle; the other gnt stays 0.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry; c = majority(a_sh[0], b_sh[0], carry).
  - Shift a_sh/b_sh right; shift s into the result register MSB (result fills LSB-first); carry<=c; cnt++.
- Completion: at the WIDTH-th RUN edge (cnt==WIDTH-1):
  - sum <= final result; cout <= c; done_id <= id; done<=1 for one cycle.
  - Return to IDLE.
- Latency: req sampled at edge k -> done high from edge k+WIDTH to edge k+WIDTH+1.
  - A new request can be sampled at edge k+WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- Requester protocol:
  - Operands must be valid on the edge req is sampled.
  - The requester deasserts req on seeing gnt. req still high during the gnt cycle is ignored because the block is in RUN.
- Requests while busy: no gnt, no capture; the request stays pending until the block returns to IDLE.
- Reset mid-operation: abort the add; no done; outputs cleared as above.
- sum/cout/done_id are stable between done pulses.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output ovf (1 bit) = (carry into MSB) XOR (carry out of MSB) of the completed add.
  - ovf is updated with sum and reset to 0.
- Undefined: no ovf port and no related logic.

Test Plan:
- Single add, WIDTH=8, req0: a0=0x5A, b0=0x3C, cin0=0 -> gnt0 pulses; done after 8 RUN edges; sum=0x96, cout=0, done_id=0.
- Wrap-around, req1: a1=0xFF, b1=0x01, cin1=0 -> sum=0x00, cout=1, done_id=1. With SERIAL_ADD_OVF_EN: ovf=0.
- Simultaneous req0=req1=1 right after reset -> gnt0 first (sum/done_id=0). Next IDLE -> gnt1 (done_id=1). Both held again -> gnt0.
- Overlap: req1 asserted mid-RUN of requester 0's op -> no gnt1 until the IDLE cycle after done; gnt1 then follows at the next edge.
- Reset mid-op: rst_n low during RUN cnt=3 -> no done; sum=0, cout=0, busy=0; next req0 (a=0x01, b=0x01, cin=1) -> sum=0x03.
- With SERIAL_ADD_OVF_EN: a=0x7F, b=0x01, cin=0 -> sum=0x80, cout=0, ovf=1.
